// File: rtl/div_dispatch_scheduler_pkg.sv
// Shared types and defaults for the divider dispatch scheduler.
`ifndef TAG_SIZE
`define TAG_SIZE 6
`endif
`ifndef MAX_INFLIGHT
`define MAX_INFLIGHT 32
`endif

package div_dispatch_scheduler_pkg;

    localparam int unsigned DIV_COUNT_DEF    = 16;
    localparam int unsigned TAG_SIZE_DEF     = `TAG_SIZE;
    localparam int unsigned MAX_INFLIGHT_DEF = `MAX_INFLIGHT;

    // Result tag carried alongside each dispatched item (reused by the length path).
    typedef logic [`TAG_SIZE-1:0] tag_t;

    // Width of a counter that must hold 0..max_inflight inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_inflight);
        return $clog2(max_inflight + 1);
    endfunction

endpackage

// File: rtl/div_dispatch_scheduler_if.sv
// Handshake bundle between the TDL FIFO / divider pool / sorted_fifo and the scheduler.
interface div_dispatch_scheduler_if
    import div_dispatch_scheduler_pkg::*;
#(
    parameter int unsigned DIV_COUNT    = DIV_COUNT_DEF,
    parameter int unsigned TAG_SIZE     = TAG_SIZE_DEF,
    parameter int unsigned MAX_INFLIGHT = MAX_INFLIGHT_DEF
);
    localparam int unsigned CNT_W = cnt_width(MAX_INFLIGHT);

    logic                 enable;
    logic                 src_valid;
    logic                 src_read;
    logic [DIV_COUNT-1:0] div_ready;
    logic [DIV_COUNT-1:0] div_start;
    logic [TAG_SIZE-1:0]  dispatch_tag;
    logic                 retire;
    logic [CNT_W-1:0]     inflight_count;
    logic                 stall;
    logic                 retire_err;

    modport master (
        output enable, src_valid, div_ready, retire,
        input  src_read, div_start, dispatch_tag, inflight_count, stall, retire_err
    );

    modport slave (
        input  enable, src_valid, div_ready, retire,
        output src_read, div_start, dispatch_tag, inflight_count, stall, retire_err
    );
endinterface

// File: rtl/div_dispatch_scheduler_rr_pick_onehot.sv
// Rotating-priority picker: first set request at or above ptr, wrapping to bit 0.
module rr_pick_onehot #(
    parameter int unsigned N = 16
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [N-1:0]         gnt_o,
    output logic [$clog2(N)-1:0] gnt_idx_o,
    output logic                 any_o
);
    localparam int unsigned PTR_W = $clog2(N);
    localparam int unsigned DW    = 2 * N;

    logic [DW-1:0] dbl_c;
    int unsigned   sel_c;

    // Low copy masked below ptr, high copy unmasked supplies the wrap-around.
    always_comb begin
        dbl_c = {req_i, req_i} & ~((DW'(1) << ptr_i) - DW'(1));
        sel_c = 0;
        for (int i = int'(DW) - 1; i >= 0; i--) begin
            if (dbl_c[i]) begin
                sel_c = 32'(i);
            end
        end
        if (sel_c >= N) begin
            sel_c = sel_c - N;
        end
        any_o     = |req_i;
        gnt_idx_o = PTR_W'(sel_c);
        gnt_o     = any_o ? (N'(1) << gnt_idx_o) : '0;
    end
endmodule

// File: rtl/div_dispatch_scheduler.sv
// Pops the TDL FIFO head into one idle divider per cycle and tracks in-flight results.
module div_dispatch_scheduler
    import div_dispatch_scheduler_pkg::*;
#(
    parameter int unsigned DIV_COUNT    = DIV_COUNT_DEF,
    parameter int unsigned TAG_SIZE     = TAG_SIZE_DEF,
    parameter int unsigned MAX_INFLIGHT = MAX_INFLIGHT_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    div_dispatch_scheduler_if.slave  bus
);
    localparam int unsigned CNT_W = cnt_width(MAX_INFLIGHT);
    localparam int unsigned PTR_W = $clog2(DIV_COUNT);

    // Live tags stay unique only if the window never exceeds the tag space.
    if (MAX_INFLIGHT > (2 ** TAG_SIZE)) begin : g_cfg_check
        $error("MAX_INFLIGHT exceeds the tag space");
    end

    logic [TAG_SIZE-1:0]  tag_q, tag_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]     inflight_q, inflight_d;
    logic [DIV_COUNT-1:0] recent_mask_q, recent_mask_d;
    logic                 retire_err_q, retire_err_d;

    logic [DIV_COUNT-1:0] eligible_c, gnt_c, div_start_c;
    logic [PTR_W-1:0]     gnt_idx_c;
    logic                 any_c, not_full_c, dispatch_c;

    // A divider granted last cycle still shows ready for one cycle; hide it.
    assign eligible_c = bus.div_ready & ~recent_mask_q;

    rr_pick_onehot #(.N(DIV_COUNT)) u_pick (
        .req_i     (eligible_c),
        .ptr_i     (rr_ptr_q),
        .gnt_o     (gnt_c),
        .gnt_idx_o (gnt_idx_c),
        .any_o     (any_c)
    );

    // Dispatch decision and next-state for tag, pointer, mask and in-flight count.
    always_comb begin
        tag_d         = tag_q;
        rr_ptr_d      = rr_ptr_q;
        inflight_d    = inflight_q;
        retire_err_d  = retire_err_q;
        not_full_c    = inflight_q < CNT_W'(MAX_INFLIGHT);
        dispatch_c    = ~reset & bus.enable & bus.src_valid & any_c & not_full_c;
        div_start_c   = dispatch_c ? gnt_c : '0;
        recent_mask_d = div_start_c;

        if (dispatch_c) begin
            tag_d    = tag_q + TAG_SIZE'(1);
            rr_ptr_d = (gnt_idx_c == PTR_W'(DIV_COUNT - 1)) ? '0 : gnt_idx_c + PTR_W'(1);
        end

        if (bus.retire && (inflight_q == '0)) begin
            retire_err_d = 1'b1;
        end

        if (dispatch_c && !bus.retire) begin
            inflight_d = inflight_q + CNT_W'(1);
        end else if (!dispatch_c && bus.retire && (inflight_q != '0)) begin
            inflight_d = inflight_q - CNT_W'(1);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_q         <= '0;
            rr_ptr_q      <= '0;
            inflight_q    <= '0;
            recent_mask_q <= '0;
            retire_err_q  <= 1'b0;
        end else begin
            tag_q         <= tag_d;
            rr_ptr_q      <= rr_ptr_d;
            inflight_q    <= inflight_d;
            recent_mask_q <= recent_mask_d;
            retire_err_q  <= retire_err_d;
        end
    end

    assign bus.src_read       = dispatch_c;
    assign bus.div_start      = div_start_c;
    assign bus.dispatch_tag   = tag_q;
    assign bus.stall          = ~reset & bus.src_valid & ~dispatch_c;
    assign bus.inflight_count = inflight_q;
    assign bus.retire_err     = retire_err_q;

    // Structural invariants of the dispatch path.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert ($onehot0(div_start_c));
            assert (inflight_q <= CNT_W'(MAX_INFLIGHT));
            assert (!dispatch_c || bus.src_valid);
        end
    end
endmodule
